// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//   state_t  : transaction sequencer states (IDLE -> ISSUE -> RESP)
//   owner_t  : which requester owns the transaction in flight
//   MAX_WAIT_DEF : default bound on consecutive host arbitration losses
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } owner_t;

  localparam int MAX_WAIT_DEF = 3;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer for the single-port data memory.
// Each access is a fixed three-cycle transaction: grant (IDLE) -> ISSUE -> RESP,
// with the completion pulse in the following IDLE cycle. The CPU port has fixed
// priority; a saturating wait counter forces the host in after MAX_WAIT losses.
//
// Ports:
//   clk, rst                                   clock, async active-high reset
//   cpu_req/cpu_wr/cpu_addr/cpu_wdata          CPU request (held until cpu_done)
//   cpu_rdata, cpu_done, cpu_stall             CPU load data, completion, freeze
//   host_req/host_wr/host_addr/host_wdata      host request (held until host_ack)
//   host_rdata, host_ack                       host load data, completion
//   mem_addr, mem_wdata, mem_wr, mem_rdata     data-memory interface
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  state_t            state;
  owner_t            owner;
  logic [WAIT_W-1:0] wait_cnt;
  logic              txn_wr;

  logic              grant_any;
  logic              grant_host;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Grant decision and request mux (used only in IDLE)
  always_comb begin
    grant_any  = cpu_req | host_req;
    grant_host = host_req & (~cpu_req | (wait_cnt == WAIT_MAX));
    if (grant_host) begin
      sel_wr    = host_wr;
      sel_addr  = host_addr;
      sel_wdata = host_wdata;
    end else begin
      sel_wr    = cpu_wr;
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
    end
  end

  // cpu_done is registered, so the stall drops in the completion cycle itself.
  assign cpu_stall = cpu_req & ~cpu_done;

  // Transaction sequencer; mem_addr/mem_wdata double as the latched request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      wait_cnt   <= '0;
      txn_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 1'b0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
      cpu_done   <= 1'b0;
      host_ack   <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_wr    <= sel_wr;
            txn_wr    <= sel_wr;
            owner     <= grant_host ? OWN_HOST : OWN_CPU;
            if (grant_host) begin
              wait_cnt <= '0;
            end else if (host_req && (wait_cnt != WAIT_MAX)) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          mem_wr <= 1'b0;
          state  <= RESP;
        end
        RESP: begin
          // Read data is valid one cycle after the address appeared in ISSUE.
          if (!txn_wr) begin
            if (owner == OWN_CPU) cpu_rdata  <= mem_rdata;
            else                  host_rdata <= mem_rdata;
          end
          if (owner == OWN_CPU) cpu_done <= 1'b1;
          else                  host_ack <= 1'b1;
          state <= IDLE;
        end
        default: begin
          mem_wr <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single transactions plus
// hand-written sequences for contention, early request drop, reset abort and
// back-to-back loads. Contains a word-addressed memory model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_done, cpu_stall;
  logic        host_req, host_wr;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        host_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr;

  int errors = 0;
  int checks = 0;

  dmem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_done   (cpu_done),
    .cpu_stall  (cpu_stall),
    .host_req   (host_req),
    .host_wr    (host_wr),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .host_ack   (host_ack),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: registered read, one-cycle write; preload port for setup.
  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = a[9:2];
    pre_data = d;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic run_txn(input logic host, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output int wrc,
                         output int stallc, output logic [31:0] iss_addr,
                         output logic stall_at_done);
    @(negedge clk);
    if (host) begin
      host_req = 1'b1; host_wr = wr; host_addr = addr; host_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    end
    #1;
    lat = 0; wrc = 0; stallc = 0; iss_addr = '0;
    while (lat < 12) begin
      if (mem_wr) wrc++;
      if (cpu_stall) stallc++;
      if (lat == 1) iss_addr = mem_addr;
      @(negedge clk); #1;
      lat++;
      if (host ? host_ack : cpu_done) break;
    end
    stall_at_done = cpu_stall;
    cpu_req  = 1'b0;
    host_req = 1'b0;
  endtask

  typedef struct {
    logic        host;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, wrc, stallc;
    logic [31:0] iss_addr;
    logic        sad;
    logic [31:0] exp_cpu_rd, exp_host_rd;
    logic [31:0] a;
    int          seq [8];
    int          tcyc [8];
    int          n, cyc, k, dn, wc;
    logic [31:0] bexp [3];

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h12345678, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'h12345678};
    vecs[3] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h30, 32'h0,        32'hA5A5A5A5};
    vecs[6] = '{1'b0, 1'b0, 32'h04, 32'h0,        32'h000000A4};

    rst = 1'b1;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    preload(32'h00, 32'h000000A0);
    preload(32'h04, 32'h000000A4);
    preload(32'h08, 32'h000000A8);
    preload(32'h10, 32'hDEADBEEF);
    preload(32'h40, 32'h0);
    preload(32'h50, 32'h0);

    // Reset values
    #1;
    check("rst_mem_addr",   mem_addr, 32'h0);
    check("rst_mem_wdata",  mem_wdata, 32'h0);
    check("rst_mem_wr",     32'(mem_wr), 32'h0);
    check("rst_cpu_rdata",  cpu_rdata, 32'h0);
    check("rst_host_rdata", host_rdata, 32'h0);
    check("rst_cpu_done",   32'(cpu_done), 32'h0);
    check("rst_host_ack",   32'(host_ack), 32'h0);
    cpu_req = 1'b1; #1;
    check("rst_stall_hi",   32'(cpu_stall), 32'h1);
    cpu_req = 1'b0; #1;
    check("rst_stall_lo",   32'(cpu_stall), 32'h0);
    @(negedge clk); rst = 1'b0;

    // Table-driven single transactions
    exp_cpu_rd  = 32'h0;
    exp_host_rd = 32'h0;
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].host, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              lat, wrc, stallc, iss_addr, sad);
      if (!vecs[i].wr) begin
        if (vecs[i].host) exp_host_rd = vecs[i].exp;
        else              exp_cpu_rd  = vecs[i].exp;
      end
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("v%0d_issue_addr", i), iss_addr, vecs[i].addr);
      check($sformatf("v%0d_wr_cycles", i), 32'(wrc), vecs[i].wr ? 32'd1 : 32'd0);
      check($sformatf("v%0d_stall_cycles", i), 32'(stallc), vecs[i].host ? 32'd0 : 32'd3);
      check($sformatf("v%0d_stall_at_done", i), 32'(sad), 32'h0);
      check($sformatf("v%0d_cpu_rdata", i), cpu_rdata, exp_cpu_rd);
      check($sformatf("v%0d_host_rdata", i), host_rdata, exp_host_rd);
      @(negedge clk); #1;
      check($sformatf("v%0d_pulse_width", i), 32'({cpu_done, host_ack}), 32'h0);
      if (vecs[i].wr) begin
        a = vecs[i].addr;
        check($sformatf("v%0d_mem", i), mem[a[9:2]], vecs[i].wdata);
      end
    end

    // Contention: both requests held, fresh wait counter
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1;  cpu_wr = 1'b0;  cpu_addr = 32'h00;
    host_req = 1'b1; host_wr = 1'b0; host_addr = 32'h04;
    n = 0; cyc = 0;
    while (n < 8 && cyc < 40) begin
      @(negedge clk); #1; cyc++;
      if (cpu_done)      begin seq[n] = 0; tcyc[n] = cyc; n++; end
      else if (host_ack) begin seq[n] = 1; tcyc[n] = cyc; n++; end
    end
    cpu_req = 1'b0; host_req = 1'b0;
    check("cont_count", 32'(n), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        check($sformatf("cont_grant%0d", i), 32'(seq[i]), (i == 3 || i == 7) ? 32'd1 : 32'd0);
        check($sformatf("cont_time%0d", i), 32'(tcyc[i]), 32'(3 * (i + 1)));
      end
    end
    check("cont_cpu_rdata", cpu_rdata, 32'h000000A0);
    check("cont_host_rdata", host_rdata, 32'h000000A4);

    // CPU store with request dropped during ISSUE
    @(negedge clk); @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hCAFEF00D;
    @(negedge clk); #1;
    check("drop_issue_wr", 32'(mem_wr), 32'h1);
    cpu_req = 1'b0;
    dn = 0; wc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (cpu_done) dn++;
      if (mem_wr) wc++;
    end
    check("drop_done_count", 32'(dn), 32'd1);
    check("drop_extra_writes", 32'(wc), 32'd0);
    a = 32'h40;
    check("drop_mem", mem[a[9:2]], 32'hCAFEF00D);

    // Reset asserted during ISSUE of a store
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'h11111111;
    @(negedge clk); #1;
    check("rstabt_issue_wr", 32'(mem_wr), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rstabt_wr_async", 32'(mem_wr), 32'h0);
    cpu_req = 1'b0;
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (cpu_done || host_ack) dn++;
    end
    check("rstabt_no_done", 32'(dn), 32'd0);
    rst = 1'b0;
    a = 32'h50;
    check("rstabt_mem", mem[a[9:2]], 32'h0);
    check("rstabt_rdata", cpu_rdata, 32'h0);
    run_txn(1'b0, 1'b0, 32'h10, 32'h0, lat, wrc, stallc, iss_addr, sad);
    check("rstabt_fresh_latency", 32'(lat), 32'd3);
    check("rstabt_fresh_rdata", cpu_rdata, 32'hDEADBEEF);

    // Back-to-back CPU loads with cpu_req held
    bexp[0] = 32'h000000A0; bexp[1] = 32'h000000A4; bexp[2] = 32'h000000A8;
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h00;
    k = 0; cyc = 0;
    while (k < 3 && cyc < 20) begin
      @(negedge clk); #1; cyc++;
      if (cpu_done) begin
        check($sformatf("b2b_time%0d", k), 32'(cyc), 32'(3 * (k + 1)));
        check($sformatf("b2b_rdata%0d", k), cpu_rdata, bexp[k]);
        k++;
        if (k < 3) cpu_addr = 32'(4 * k);
        else       cpu_req = 1'b0;
      end else if (k > 0) begin
        check($sformatf("b2b_hold_c%0d", cyc), cpu_rdata, bexp[k-1]);
      end
    end
    check("b2b_count", 32'(k), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencing controller and two-port arbiter for the single-port data memory used by the memory stage. Shares the data memory between the pipeline memory stage (CPU port) and an external host/loader port (program load, debug readback). Every access is serialised as a fixed three-cycle transaction. The CPU port gets fixed priority, and a wait counter bounds host starvation. A stall output freezes the pipeline while a CPU access is outstanding.

## Interface
Parameters:
- DATA_W, 32, data width of all data buses
- ADDR_W, 32, address width (byte address taken from the ALU result)
- MAX_WAIT, 3, arbitration cycles the host may lose consecutively before it is forced in

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request; held with fields stable until cpu_done
- cpu_wr  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU store data
- cpu_rdata  out  DATA_W  CPU load data, registered, valid with cpu_done, held until the next CPU completion
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  pipeline freeze request
- host_req, host_wr, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host request, same rules as the CPU request
- host_rdata  out  DATA_W  host load data, same rules as cpu_rdata
- host_ack  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  data-memory address
- mem_wdata  out  DATA_W  data-memory write data
- mem_wr  out  1  data-memory write enable
- mem_rdata  in  DATA_W  data-memory read data, valid the cycle after mem_addr is presented

## Operation
- The FSM has three states: IDLE, ISSUE and RESP. The owner register selects CPU or HOST.
- **IDLE: grant decision.**
  - Only cpu_req is set: the CPU is granted.
  - Only host_req is set: the host is granted.
  - Both are set: the host is granted if wait_cnt == MAX_WAIT, otherwise the CPU is granted.
  - Neither is set: the FSM stays in IDLE.
- **IDLE: on a grant.**
  - The winner's addr, wdata and wr are latched into internal registers.
  - The owner is latched.
  - The FSM moves to ISSUE.
- **ISSUE.**
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_wr = latched wr.
  - Next state is RESP.
- **RESP.**
  - mem_addr is still driven and mem_wr = 0.
  - For a load, mem_rdata is captured into the owner's rdata register at the end of the cycle.
  - For a store, the rdata registers are unchanged.
  - Next state is IDLE.
- **Completion.**
  - The owner's done/ack pulses high for exactly one cycle: the IDLE cycle that follows RESP.
  - A new grant may be made in that same IDLE cycle.
- **wait_cnt (saturating at MAX_WAIT).**
  - Increments in an IDLE grant cycle when host_req = 1 and the CPU wins.
  - Clears when the host is granted.
  - Otherwise holds.
- **cpu_stall.** cpu_stall = cpu_req & ~cpu_done, combinational.
- **Request dropped early.** If a requester drops req mid-transaction, the transaction still completes, including a store write and the done/ack pulse.
- **Idle outputs.** mem_addr and mem_wdata hold their last values; mem_wr = 0.

## Timing
- The transaction runs grant (IDLE) → ISSUE → RESP → done pulse in the next IDLE.
- Latency from req sampled to done is 3 cycles; peak throughput is one access per 3 cycles.
- The grant in IDLE is made combinationally, on the same edge that samples the request.
- mem_wr is high only in ISSUE, for exactly one cycle per store.
- **Reset values.**
  - FSM = IDLE, owner = CPU, wait_cnt = 0.
  - mem_addr, mem_wdata, mem_wr, cpu_rdata, host_rdata, cpu_done and host_ack = 0.
  - cpu_stall follows cpu_req.
- **Reset mid-transaction.** The transaction is aborted immediately and asynchronously: mem_wr drops at once, no done/ack is issued, and no rdata is updated.
- **Simultaneous requests.** Simultaneous requests over successive IDLE cycles let the host in after at most MAX_WAIT CPU transactions.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, RESP);
  - the owner encoding (OWN_CPU = 0, OWN_HOST = 1);
  - the MAX_WAIT default.
- The block is a single module with no sub-module. The wait counter and the request mux are small enough to stay inline.

## Test plan
- **CPU load, host idle.** Preload mem[0x10] = 0xDEADBEEF, then issue cpu_req, cpu_wr = 0, addr 0x10. Required:
  - mem_addr = 0x10 in ISSUE;
  - cpu_done pulses 3 cycles after the request;
  - cpu_rdata = 0xDEADBEEF;
  - cpu_stall is high for 3 cycles, then low.
- **Host store then CPU load.**
  - host_req, host_wr = 1, addr 0x20, wdata 0x12345678: mem_wr is high for exactly 1 cycle and host_ack pulses once.
  - A following CPU load of 0x20 returns 0x12345678.
- **Contention and starvation bound.** Hold cpu_req and host_req high continuously with MAX_WAIT = 3. Required:
  - the grant sequence is CPU, CPU, CPU, HOST, CPU, CPU, CPU, HOST;
  - wait_cnt clears on every host grant.
- **Request dropped in ISSUE.** Drop cpu_req (a store) during ISSUE. Required:
  - the memory write still occurs;
  - cpu_done still pulses;
  - no second transaction starts.
- **Reset during ISSUE of a store.** Assert rst during ISSUE of a store. Required:
  - mem_wr falls with no clock edge;
  - no done/ack is issued;
  - after release, the FSM is in IDLE and a fresh CPU load completes normally in 3 cycles.
- **Back-to-back CPU loads.** Issue CPU loads 0x0, 0x4, 0x8 with cpu_req held. Required:
  - done pulses spaced exactly 3 cycles apart;
  - cpu_rdata updates at each pulse and holds between pulses.
